// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction ROM port plus the IF/ID register outputs.
// The master side is the fetch stage. The slave side is the ROM and decode.
interface fetch_stage_if #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32
);
    logic [PC_W-1:0]    imem_addr_o;
    logic               imem_rd_o;
    logic [INSTR_W-1:0] imem_instr_i;
    logic [PC_W-1:0]    ifid_pc_o;
    logic [INSTR_W-1:0] ifid_instr_o;
    logic               ifid_valid_o;

    modport master (
        output imem_addr_o,
        output imem_rd_o,
        input  imem_instr_i,
        output ifid_pc_o,
        output ifid_instr_o,
        output ifid_valid_o
    );

    modport slave (
        input  imem_addr_o,
        input  imem_rd_o,
        output imem_instr_i,
        input  ifid_pc_o,
        input  ifid_instr_o,
        input  ifid_valid_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle synchronous ROM and
// loads the IF/ID register. A one-entry hold buffer keeps the word returned
// by the ROM when a stall begins, so no fetched word is lost. A flush
// redirects the PC and inserts bubbles.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetch; the ROM output belongs to rsp_pc_q
// HOLD  | stalled; the word for rsp_pc_q is parked in hold_q
module fetch_stage #(
    parameter int                 PC_W     = 9,
    parameter int                 INSTR_W  = 32,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP      = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [PC_W-1:0]  branch_pc_i,
    fetch_stage_if.master    bus
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t             state_q;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    rsp_pc_q;
    logic               rsp_vld_q;
    logic [INSTR_W-1:0] hold_q;
    logic               hold_vld_q;
    logic [PC_W-1:0]    ifid_pc_q;
    logic [INSTR_W-1:0] ifid_instr_q;
    logic               ifid_valid_q;
    logic [INSTR_W-1:0] src_word;

    // Next PC: a redirect target is word-aligned on load; sequential fetch wraps.
    always_comb begin
        pc_d = pc_q;
        if (flush_i) begin
            pc_d = {branch_pc_i[PC_W-1:2], 2'b00};
        end else if (!stall_i) begin
            pc_d = pc_q + PC_W'(4);
        end
    end

    // After a stall, the parked word replaces the stale ROM output.
    always_comb begin
        src_word = hold_vld_q ? hold_q : bus.imem_instr_i;
    end

    // PC, response tracking, hold buffer and IF/ID register.
    // Priority: flush > stall > advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            rsp_pc_q     <= '0;
            rsp_vld_q    <= 1'b0;
            hold_q       <= NOP;
            hold_vld_q   <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
        end else if (flush_i) begin
            pc_q         <= pc_d;
            rsp_vld_q    <= 1'b0;
            hold_vld_q   <= 1'b0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            state_q      <= RUN;
        end else if (stall_i) begin
            // Only the first stall cycle captures. Later cycles keep the parked word.
            if (state_q == RUN) begin
                hold_q     <= bus.imem_instr_i;
                hold_vld_q <= rsp_vld_q;
                state_q    <= HOLD;
            end
        end else begin
            ifid_pc_q    <= rsp_pc_q;
            // A bubble must never carry an unread ROM word, so substitute NOP.
            ifid_instr_q <= rsp_vld_q ? src_word : NOP;
            ifid_valid_q <= rsp_vld_q;
            rsp_pc_q     <= pc_q;
            rsp_vld_q    <= 1'b1;
            pc_q         <= pc_d;
            hold_vld_q   <= 1'b0;
            state_q      <= RUN;
        end
    end

    assign bus.imem_addr_o  = pc_q;
    assign bus.imem_rd_o    = reset & ~stall_i & ~flush_i;
    assign bus.ifid_pc_o    = ifid_pc_q;
    assign bus.ifid_instr_o = ifid_instr_q;
    assign bus.ifid_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. A ROM model returns garbage after any cycle that did
// not read it. A queue-based model of the fetch stream tracks the expected
// IF/ID contents. Directed scenarios with literal expectations run first,
// followed by randomized stall/flush/reset traffic.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic       flush;
    logic [8:0] bpc;

    always #5 clk = ~clk;

    fetch_stage_if #(.PC_W(9), .INSTR_W(32)) bus ();

    fetch_stage dut (
        .clk         (clk),
        .reset       (rst_n),
        .stall_i     (stall),
        .flush_i     (flush),
        .branch_pc_i (bpc),
        .bus         (bus)
    );

    function automatic logic [31:0] rom_word(input logic [8:0] a);
        return 32'h1000_0000 + {25'd0, a[8:2]};
    endfunction

    // Synchronous ROM. When it was not read, its output is undefined (random here).
    always @(posedge clk) begin
        if (bus.imem_rd_o) bus.imem_instr_i <= rom_word(bus.imem_addr_o);
        else               bus.imem_instr_i <= $urandom;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: next fetch address plus a queue of issued fetches
    // that have not yet reached IF/ID.
    logic [8:0]  m_pc;
    logic [8:0]  m_q[$];
    logic        m_val;
    logic [8:0]  m_ifpc;
    logic [31:0] m_ins;

    task automatic m_reset();
        m_pc = 9'h000;
        m_q.delete();
        m_val = 1'b0;
        m_ifpc = 9'h000;
        m_ins = NOP;
    endtask

    task automatic m_edge(input logic s, input logic f, input logic [8:0] b);
        if (!rst_n) begin
            m_reset();
        end else if (f) begin
            m_pc = {b[8:2], 2'b00};
            m_q.delete();
            m_val = 1'b0;
            m_ins = NOP;
        end else if (!s) begin
            if (m_q.size() > 0) begin
                m_ifpc = m_q.pop_front();
                m_ins = rom_word(m_ifpc);
                m_val = 1'b1;
            end else begin
                m_val = 1'b0;
            end
            m_q.push_back(m_pc);
            m_pc = m_pc + 9'd4;
        end
    endtask

    // Compare process: DUT against the model on every falling edge.
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_addr", 32'(bus.imem_addr_o), 32'(m_pc));
            chk("imem_rd", 32'(bus.imem_rd_o), 32'(rst_n & ~stall & ~flush));
            chk("ifid_valid", 32'(bus.ifid_valid_o), 32'(m_val));
            if (m_val) begin
                chk("ifid_pc", 32'(bus.ifid_pc_o), 32'(m_ifpc));
                chk("ifid_instr", bus.ifid_instr_o, m_ins);
            end
        end
    end

    // Drive the inputs for one cycle, take the edge, then advance the model.
    // Returns 2 time units after the rising edge.
    task automatic step(input logic s, input logic f, input logic [8:0] b);
        stall = s;
        flush = f;
        bpc = b;
        @(posedge clk);
        m_edge(s, f, b);
        #2;
    endtask

    // Literal IF/ID expectation, checked against both the DUT and the model.
    task automatic lit(input string nm, input logic v, input logic [8:0] pc, input logic [31:0] ins);
        chk({nm, "_valid"}, 32'(bus.ifid_valid_o), 32'(v));
        chk({nm, "_model_valid"}, 32'(m_val), 32'(v));
        if (v) begin
            chk({nm, "_pc"}, 32'(bus.ifid_pc_o), 32'(pc));
            chk({nm, "_instr"}, bus.ifid_instr_o, ins);
            chk({nm, "_model_instr"}, m_ins, ins);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        bpc = 9'h000;
        m_reset();
        chk_en = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 9'h000);
        step(1'b0, 1'b0, 9'h000);
        chk("rst_pc", 32'(bus.ifid_pc_o), 32'h0);
        chk("rst_instr", bus.ifid_instr_o, NOP);
        chk("rst_valid", 32'(bus.ifid_valid_o), 32'h0);
        chk("rst_rd", 32'(bus.imem_rd_o), 32'h0);
        chk("rst_addr", 32'(bus.imem_addr_o), 32'h0);

        // T1: straight-line fetch after reset release
        rst_n = 1'b1;
        step(1'b0, 1'b0, 9'h000); lit("t1_e1", 1'b0, 9'h000, 32'h0);
        step(1'b0, 1'b0, 9'h000); lit("t1_e2", 1'b1, 9'h000, 32'h1000_0000);
        step(1'b0, 1'b0, 9'h000); lit("t1_e3", 1'b1, 9'h004, 32'h1000_0001);

        // T2: three stall cycles while PC 008 is in flight
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 9'h000);
            lit("t2_stall", 1'b1, 9'h004, 32'h1000_0001);
        end
        step(1'b0, 1'b0, 9'h000); lit("t2_rel0", 1'b1, 9'h008, 32'h1000_0002);
        step(1'b0, 1'b0, 9'h000); lit("t2_rel1", 1'b1, 9'h00C, 32'h1000_0003);

        // T3: flush to 040
        step(1'b0, 1'b1, 9'h040);
        lit("t3_flush", 1'b0, 9'h000, 32'h0);
        chk("t3_nop", bus.ifid_instr_o, NOP);
        chk("t3_addr", 32'(bus.imem_addr_o), 32'h040);
        step(1'b0, 1'b0, 9'h000); lit("t3_bub", 1'b0, 9'h000, 32'h0);
        step(1'b0, 1'b0, 9'h000); lit("t3_tgt", 1'b1, 9'h040, 32'h1000_0010);
        step(1'b0, 1'b0, 9'h000); lit("t3_nxt", 1'b1, 9'h044, 32'h1000_0011);

        // T4: flush together with stall while in HOLD
        step(1'b1, 1'b0, 9'h000);
        step(1'b1, 1'b1, 9'h080);
        lit("t4_flush", 1'b0, 9'h000, 32'h0);
        chk("t4_nop", bus.ifid_instr_o, NOP);
        chk("t4_addr", 32'(bus.imem_addr_o), 32'h080);
        step(1'b0, 1'b0, 9'h000); lit("t4_bub", 1'b0, 9'h000, 32'h0);
        step(1'b0, 1'b0, 9'h000); lit("t4_tgt", 1'b1, 9'h080, 32'h1000_0020);

        // T5: PC wrap and an unaligned branch target
        step(1'b0, 1'b1, 9'h1FC);
        chk("t5_addr_top", 32'(bus.imem_addr_o), 32'h1FC);
        step(1'b0, 1'b0, 9'h000);
        chk("t5_wrap", 32'(bus.imem_addr_o), 32'h000);
        step(1'b0, 1'b0, 9'h000); lit("t5_top", 1'b1, 9'h1FC, 32'h1000_007F);
        step(1'b0, 1'b0, 9'h000); lit("t5_zero", 1'b1, 9'h000, 32'h1000_0000);
        step(1'b0, 1'b1, 9'h043);
        chk("t5_align", 32'(bus.imem_addr_o), 32'h040);
        step(1'b0, 1'b0, 9'h000);
        step(1'b0, 1'b0, 9'h000); lit("t5_tgt", 1'b1, 9'h040, 32'h1000_0010);

        // T6: asynchronous reset in the middle of HOLD
        step(1'b1, 1'b0, 9'h000);
        step(1'b1, 1'b0, 9'h000);
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("t6_pc", 32'(bus.ifid_pc_o), 32'h0);
        chk("t6_instr", bus.ifid_instr_o, NOP);
        chk("t6_valid", 32'(bus.ifid_valid_o), 32'h0);
        chk("t6_rd", 32'(bus.imem_rd_o), 32'h0);
        chk("t6_addr", 32'(bus.imem_addr_o), 32'h0);
        step(1'b0, 1'b0, 9'h000);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 9'h000); lit("t6_e1", 1'b0, 9'h000, 32'h0);
        step(1'b0, 1'b0, 9'h000); lit("t6_e2", 1'b1, 9'h000, 32'h1000_0000);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(99));
            if (r < 2) begin
                rst_n = 1'b0;
                m_reset();
            end else if (!rst_n) begin
                rst_n = 1'b1;
            end
            step(1'($urandom_range(99) < 30), 1'($urandom_range(99) < 10), 9'($urandom));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
